// File: rtl/seq_fetch_ctl_pkg.sv
// Shared definitions for the Seq program fetch controller and its benches.
// Holds the Seq instruction format (4-bit opcode + 16-bit operand), the Seq
// opcode values, the default bus widths and the controller FSM state encodings.
// The state encodings are plain localparams so that older benches can compare
// the debug state output against plain numbers.
package seq_fetch_ctl_pkg;

  localparam int SEQ_ADDR_W = 8;
  localparam int SEQ_OPC_W  = 4;
  localparam int SEQ_OPND_W = 16;
  localparam int SEQ_INST_W = SEQ_OPC_W + SEQ_OPND_W;
  localparam int SEQ_CNT_W  = 16;

  // Seq opcodes
  localparam logic [SEQ_OPC_W-1:0] OP_CI = 4'h0;
  localparam logic [SEQ_OPC_W-1:0] OP_CR = 4'h1;
  localparam logic [SEQ_OPC_W-1:0] OP_JI = 4'h2;
  localparam logic [SEQ_OPC_W-1:0] OP_JR = 4'h3;
  localparam logic [SEQ_OPC_W-1:0] OP_JZ = 4'h4;
  localparam logic [SEQ_OPC_W-1:0] OP_JN = 4'h5;
  localparam logic [SEQ_OPC_W-1:0] OP_NO = 4'h6;

  // Controller FSM encodings, visible on the debug state output
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RESTART = 3'd1;
  localparam logic [2:0] ST_FETCH   = 3'd2;
  localparam logic [2:0] ST_ISSUE   = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  typedef struct packed {
    logic [SEQ_OPC_W-1:0]  opcode;
    logic [SEQ_OPND_W-1:0] operand;
  } seq_inst_t;

  // Assemble one Seq instruction word
  function automatic logic [SEQ_INST_W-1:0] make_inst(input logic [SEQ_OPC_W-1:0] op,
                                                      input logic [SEQ_OPND_W-1:0] opnd);
    seq_inst_t w;
    w.opcode  = op;
    w.operand = opnd;
    return w;
  endfunction

endpackage

// File: rtl/seq_fetch_ctl_if.sv
// Bus bundle between the host/Seq side and the fetch controller.
//   load_addr/load_data/load_wen : host program write port
//   cmd_run/cmd_step/cmd_halt    : single-cycle control pulses
//   bp_en/bp_addr                : breakpoint
//   next                         : Seq next-instruction address
//   seq_reset/inst/inst_en       : controller outputs towards Seq
//   state/issued                 : debug FSM state and issue counter
// The controller uses the slave modport; the host/Seq side uses master.
interface seq_fetch_ctl_if #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 20,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] load_addr;
  logic [INST_W-1:0] load_data;
  logic              load_wen;
  logic              cmd_run;
  logic              cmd_step;
  logic              cmd_halt;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] next;
  logic              seq_reset;
  logic [INST_W-1:0] inst;
  logic              inst_en;
  logic [2:0]        state;
  logic [CNT_W-1:0]  issued;

  modport master (
    output load_addr, load_data, load_wen, cmd_run, cmd_step, cmd_halt,
           bp_en, bp_addr, next,
    input  seq_reset, inst, inst_en, state, issued
  );

  modport slave (
    input  load_addr, load_data, load_wen, cmd_run, cmd_step, cmd_halt,
           bp_en, bp_addr, next,
    output seq_reset, inst, inst_en, state, issued
  );
endinterface

// File: rtl/seq_fetch_ctl_imem.sv
// Program memory for the Seq fetch controller: 2^ADDR_W x INST_W words,
// one write port and one synchronous read port.
//   clock, reset        : clock and async active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr       : read request, data appears on rd_data one cycle later
//   rd_data             : registered read data, held while rd_en is low
module seq_fetch_ctl_imem #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [INST_W-1:0] rd_data
);

  logic [INST_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [INST_W-1:0] rd_data_q;

  // Storage array is deliberately not reset so a program survives a controller reset
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read register holds the last fetched word, which is what Seq sees between issues
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/seq_fetch_ctl.sv
// Program fetch/issue controller for the Seq sequencer.
// Keeps the program in a local memory and hands Seq one instruction at a time,
// addressed by Seq's own next output. Provides run/step/halt control, a single
// breakpoint and a saturating issued-instruction counter.
//   clock : single clock, rising edge
//   reset : asynchronous active-low; clears everything except program memory
//   bus   : seq_fetch_ctl_if.slave (host load port, commands, breakpoint,
//           Seq next input, seq_reset/inst/inst_en outputs, debug state/issued)
module seq_fetch_ctl
  import seq_fetch_ctl_pkg::*;
#(
  parameter int ADDR_W = SEQ_ADDR_W,
  parameter int INST_W = SEQ_INST_W,
  parameter int CNT_W  = SEQ_CNT_W
) (
  input  logic           clock,
  input  logic           reset,
  seq_fetch_ctl_if.slave bus
);

  logic [2:0]       state_q,     state_d;
  logic             seq_reset_q, seq_reset_d;
  logic             inst_en_q,   inst_en_d;
  logic [CNT_W-1:0] issued_q,    issued_d;
  logic             skip_bp_q,   skip_bp_d;
  logic             step_q,      step_d;
  logic             halt_req_q,  halt_req_d;
  logic             rd_en;
  logic             wr_en;
  logic             bp_hit;

  // Host writes are only safe while nothing is being fetched
  assign wr_en  = bus.load_wen && (state_q == ST_IDLE || state_q == ST_HALT);
  assign bp_hit = bus.bp_en && (bus.next == bus.bp_addr) && !skip_bp_q;

  seq_fetch_ctl_imem #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_imem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (bus.load_addr),
    .wr_data (bus.load_data),
    .rd_en   (rd_en),
    .rd_addr (bus.next),
    .rd_data (bus.inst)
  );

  // Next-state logic. seq_reset and inst_en are computed one cycle ahead so they
  // are registered and line up exactly with the RESTART and ISSUE cycles.
  always_comb begin
    state_d     = state_q;
    seq_reset_d = 1'b0;
    inst_en_d   = 1'b0;
    issued_d    = issued_q;
    skip_bp_d   = skip_bp_q;
    step_d      = step_q;
    halt_req_d  = halt_req_q;
    rd_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_run) begin
          state_d     = ST_RESTART;
          seq_reset_d = 1'b1;
        end
      end

      ST_RESTART: begin
        issued_d   = '0;
        skip_bp_d  = 1'b0;
        step_d     = 1'b0;
        halt_req_d = 1'b0;
        state_d    = ST_FETCH;
      end

      ST_FETCH: begin
        if (bus.cmd_halt) halt_req_d = 1'b1;
        // A breakpoint stops before the read, so the instruction at bp_addr is not issued
        if (bp_hit) begin
          state_d = ST_HALT;
        end else begin
          rd_en     = 1'b1;
          inst_en_d = 1'b1;
          skip_bp_d = 1'b0;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (issued_q != {CNT_W{1'b1}}) issued_d = issued_q + 1'b1;
        // A halt arriving during ISSUE counts as well; it only takes effect after this issue
        if (halt_req_q || bus.cmd_halt || step_q) state_d = ST_HALT;
        else                                      state_d = ST_FETCH;
      end

      ST_HALT: begin
        halt_req_d = 1'b0;
        step_d     = 1'b0;
        // Halt outranks step, which outranks run; resuming skips the breakpoint once
        if (bus.cmd_halt) begin
          state_d = ST_HALT;
        end else if (bus.cmd_step) begin
          state_d   = ST_FETCH;
          skip_bp_d = 1'b1;
          step_d    = 1'b1;
        end else if (bus.cmd_run) begin
          state_d   = ST_FETCH;
          skip_bp_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      seq_reset_q <= 1'b0;
      inst_en_q   <= 1'b0;
      issued_q    <= '0;
      skip_bp_q   <= 1'b0;
      step_q      <= 1'b0;
      halt_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_reset_q <= seq_reset_d;
      inst_en_q   <= inst_en_d;
      issued_q    <= issued_d;
      skip_bp_q   <= skip_bp_d;
      step_q      <= step_d;
      halt_req_q  <= halt_req_d;
    end
  end

  assign bus.seq_reset = seq_reset_q;
  assign bus.inst_en   = inst_en_q;
  assign bus.state     = state_q;
  assign bus.issued    = issued_q;

endmodule

// File: tb/tb_seq_fetch_ctl.sv
// Directed testbench for seq_fetch_ctl. A small stand-in for Seq drives next:
// it returns to 0 on seq_reset, jumps on JI and otherwise steps by one on each
// inst_en. Program: JI 02 @0, NO @2, JI 00 @3, giving the loop 0 -> 2 -> 3 -> 0.
module tb_seq_fetch_ctl;
  import seq_fetch_ctl_pkg::*;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  seq_fetch_ctl_if #(.ADDR_W(8), .INST_W(20), .CNT_W(16)) bus ();

  seq_fetch_ctl #(.ADDR_W(8), .INST_W(20), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  localparam logic [19:0] I_JI02 = {OP_JI, 16'h0002};
  localparam logic [19:0] I_NO   = {OP_NO, 16'h0000};
  localparam logic [19:0] I_JI00 = {OP_JI, 16'h0000};
  localparam logic [19:0] I_CIAA = {OP_CI, 16'h00AA};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Seq stand-in: owns next
  always @(posedge clock or negedge reset) begin
    if (!reset)             bus.next <= 8'h00;
    else if (bus.seq_reset) bus.next <= 8'h00;
    else if (bus.inst_en)   bus.next <= (bus.inst[19:16] == OP_JI) ? bus.inst[7:0] : bus.next + 8'd1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [19:0] data);
    bus.load_addr = addr;
    bus.load_data = data;
    bus.load_wen  = 1'b1;
    tick();
    bus.load_wen  = 1'b0;
  endtask

  task automatic pulse_run();
    bus.cmd_run = 1'b1;
    tick();
    bus.cmd_run = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.load_wen  = 1'b0;
    bus.cmd_run   = 1'b0;
    bus.cmd_step  = 1'b0;
    bus.cmd_halt  = 1'b0;
    bus.bp_en     = 1'b0;
    bus.bp_addr   = '0;
    #12;
    tests_run++; if (bus.state !== ST_IDLE) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d expected %0d", bus.state, ST_IDLE); end
    tests_run++; if (bus.inst_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_inst_en: got %b expected 0", bus.inst_en); end
    tests_run++; if (bus.seq_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_seq_reset: got %b expected 0", bus.seq_reset); end
    tests_run++; if (bus.inst !== 20'h0) begin tests_failed++; $display("[TB] FAIL reset_inst: got %h expected 00000", bus.inst); end
    tests_run++; if (bus.issued !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_issued: got %0d expected 0", bus.issued); end
    @(posedge clock); #1;
    reset = 1'b1;
    load_word(8'h00, I_JI02);
    load_word(8'h02, I_NO);
    load_word(8'h03, I_JI00);
  endtask

  task automatic test_basic_run();
    logic [19:0] exp_seq [4];
    exp_seq[0] = I_JI02; exp_seq[1] = I_NO; exp_seq[2] = I_JI00; exp_seq[3] = I_JI02;
    apply_reset();
    pulse_run();
    tests_run++; if (bus.state !== ST_RESTART) begin tests_failed++; $display("[TB] FAIL run_restart_state: got %0d expected %0d", bus.state, ST_RESTART); end
    tests_run++; if (bus.seq_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL run_seq_reset_high: got %b expected 1", bus.seq_reset); end
    tick();
    tests_run++; if (bus.seq_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL run_seq_reset_one_cycle: got %b expected 0", bus.seq_reset); end
    tests_run++; if (bus.state !== ST_FETCH) begin tests_failed++; $display("[TB] FAIL run_fetch_state: got %0d expected %0d", bus.state, ST_FETCH); end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++; if (bus.inst_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL run_issue_en[%0d]: got %b expected 1", k, bus.inst_en); end
      tests_run++; if (bus.inst !== exp_seq[k]) begin tests_failed++; $display("[TB] FAIL run_issue_inst[%0d]: got %h expected %h", k, bus.inst, exp_seq[k]); end
      tests_run++; if (bus.issued !== 16'(k)) begin tests_failed++; $display("[TB] FAIL run_issued[%0d]: got %0d expected %0d", k, bus.issued, k); end
      tick();
      tests_run++; if (bus.inst_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL run_gap_en[%0d]: got %b expected 0", k, bus.inst_en); end
      tests_run++; if (bus.inst !== exp_seq[k]) begin tests_failed++; $display("[TB] FAIL run_inst_hold[%0d]: got %h expected %h", k, bus.inst, exp_seq[k]); end
    end
    tests_run++; if (bus.issued !== 16'd4) begin tests_failed++; $display("[TB] FAIL run_issued_total: got %0d expected 4", bus.issued); end
  endtask

  task automatic test_breakpoint();
    int pulses;
    apply_reset();
    bus.bp_en   = 1'b1;
    bus.bp_addr = 8'h02;
    pulse_run();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.inst_en) pulses++;
    end
    tests_run++; if (bus.state !== ST_HALT) begin tests_failed++; $display("[TB] FAIL bp_halt_state: got %0d expected %0d", bus.state, ST_HALT); end
    tests_run++; if (bus.next !== 8'h02) begin tests_failed++; $display("[TB] FAIL bp_halt_next: got %h expected 02", bus.next); end
    tests_run++; if (pulses != 1) begin tests_failed++; $display("[TB] FAIL bp_no_issue_at_bp: got %0d pulses expected 1", pulses); end
    tests_run++; if (bus.issued !== 16'd1) begin tests_failed++; $display("[TB] FAIL bp_issued: got %0d expected 1", bus.issued); end
    pulse_run();
    tick();
    tests_run++; if (bus.inst_en !== 1'b1 || bus.inst !== I_NO) begin tests_failed++; $display("[TB] FAIL bp_resume_issue: got en=%b inst=%h expected en=1 inst=%h", bus.inst_en, bus.inst, I_NO); end
    for (int i = 0; i < 6; i++) tick();
    tests_run++; if (bus.state !== ST_HALT) begin tests_failed++; $display("[TB] FAIL bp_rehalt_state: got %0d expected %0d", bus.state, ST_HALT); end
    tests_run++; if (bus.next !== 8'h02) begin tests_failed++; $display("[TB] FAIL bp_rehalt_next: got %h expected 02", bus.next); end
    tests_run++; if (bus.issued !== 16'd4) begin tests_failed++; $display("[TB] FAIL bp_rehalt_issued: got %0d expected 4", bus.issued); end
  endtask

  // Starts from the breakpoint HALT at address 02 left by test_breakpoint
  task automatic test_step();
    logic [19:0] exp_seq [3];
    logic [19:0] seen;
    int          pulses;
    exp_seq[0] = I_NO; exp_seq[1] = I_JI00; exp_seq[2] = I_JI02;
    for (int s = 0; s < 3; s++) begin
      pulses = 0;
      seen   = '0;
      bus.cmd_step = 1'b1;
      tick();
      bus.cmd_step = 1'b0;
      if (bus.inst_en) begin pulses++; seen = bus.inst; end
      for (int i = 0; i < 2; i++) begin
        tick();
        if (bus.inst_en) begin pulses++; seen = bus.inst; end
      end
      tests_run++; if (pulses != 1) begin tests_failed++; $display("[TB] FAIL step_pulses[%0d]: got %0d expected 1", s, pulses); end
      tests_run++; if (seen !== exp_seq[s]) begin tests_failed++; $display("[TB] FAIL step_inst[%0d]: got %h expected %h", s, seen, exp_seq[s]); end
      tests_run++; if (bus.state !== ST_HALT) begin tests_failed++; $display("[TB] FAIL step_state[%0d]: got %0d expected %0d", s, bus.state, ST_HALT); end
    end
    tests_run++; if (bus.issued !== 16'd7) begin tests_failed++; $display("[TB] FAIL step_issued: got %0d expected 7", bus.issued); end
  endtask

  task automatic test_halt();
    apply_reset();
    bus.bp_en = 1'b0;
    pulse_run();
    tick();
    bus.cmd_halt = 1'b1;
    tick();
    bus.cmd_halt = 1'b0;
    tests_run++; if (bus.inst_en !== 1'b1 || bus.inst !== I_JI02) begin tests_failed++; $display("[TB] FAIL halt_fetch_still_issued: got en=%b inst=%h expected en=1 inst=%h", bus.inst_en, bus.inst, I_JI02); end
    tick();
    tests_run++; if (bus.state !== ST_HALT) begin tests_failed++; $display("[TB] FAIL halt_state: got %0d expected %0d", bus.state, ST_HALT); end
    tests_run++; if (bus.next !== 8'h02) begin tests_failed++; $display("[TB] FAIL halt_next: got %h expected 02", bus.next); end
    bus.cmd_halt = 1'b1;
    bus.cmd_run  = 1'b1;
    tick();
    bus.cmd_halt = 1'b0;
    bus.cmd_run  = 1'b0;
    tests_run++; if (bus.state !== ST_HALT) begin tests_failed++; $display("[TB] FAIL halt_beats_run: got %0d expected %0d", bus.state, ST_HALT); end
    tick();
    tests_run++; if (bus.inst_en !== 1'b0 || bus.issued !== 16'd1) begin tests_failed++; $display("[TB] FAIL halt_stays_idle: got en=%b issued=%0d expected en=0 issued=1", bus.inst_en, bus.issued); end
  endtask

  task automatic test_load_gating();
    apply_reset();
    pulse_run();
    tick();
    load_word(8'h02, I_CIAA);
    tick();
    tick();
    tests_run++; if (bus.inst_en !== 1'b1 || bus.inst !== I_NO) begin tests_failed++; $display("[TB] FAIL load_dropped_running: got en=%b inst=%h expected en=1 inst=%h", bus.inst_en, bus.inst, I_NO); end
    bus.cmd_halt = 1'b1;
    tick();
    bus.cmd_halt = 1'b0;
    tests_run++; if (bus.state !== ST_HALT || bus.next !== 8'h03) begin tests_failed++; $display("[TB] FAIL load_halt_in_issue: got state=%0d next=%h expected state=%0d next=03", bus.state, bus.next, ST_HALT); end
    load_word(8'h02, I_CIAA);
    pulse_run();
    for (int i = 0; i < 5; i++) tick();
    tests_run++; if (bus.inst_en !== 1'b1 || bus.inst !== I_CIAA) begin tests_failed++; $display("[TB] FAIL load_taken_in_halt: got en=%b inst=%h expected en=1 inst=%h", bus.inst_en, bus.inst, I_CIAA); end
    bus.cmd_halt = 1'b1;
    tick();
    bus.cmd_halt = 1'b0;
    load_word(8'h02, I_NO);
    tests_run++; if (bus.state !== ST_HALT) begin tests_failed++; $display("[TB] FAIL load_restore_state: got %0d expected %0d", bus.state, ST_HALT); end
  endtask

  task automatic test_reset_mid_issue();
    apply_reset();
    pulse_run();
    for (int i = 0; i < 4; i++) tick();
    tests_run++; if (bus.inst_en !== 1'b1 || bus.issued !== 16'd1) begin tests_failed++; $display("[TB] FAIL rst_pre_issue: got en=%b issued=%0d expected en=1 issued=1", bus.inst_en, bus.issued); end
    #2;
    reset = 1'b0;
    #1;
    tests_run++; if (bus.inst_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_async_inst_en: got %b expected 0", bus.inst_en); end
    tests_run++; if (bus.state !== ST_IDLE) begin tests_failed++; $display("[TB] FAIL rst_async_state: got %0d expected %0d", bus.state, ST_IDLE); end
    tests_run++; if (bus.issued !== 16'd0) begin tests_failed++; $display("[TB] FAIL rst_async_issued: got %0d expected 0", bus.issued); end
    tick();
    reset = 1'b1;
    pulse_run();
    tick();
    tick();
    tests_run++; if (bus.inst_en !== 1'b1 || bus.inst !== I_JI02) begin tests_failed++; $display("[TB] FAIL rst_replay_first: got en=%b inst=%h expected en=1 inst=%h", bus.inst_en, bus.inst, I_JI02); end
    tick();
    tick();
    tests_run++; if (bus.inst_en !== 1'b1 || bus.inst !== I_NO) begin tests_failed++; $display("[TB] FAIL rst_replay_second: got en=%b inst=%h expected en=1 inst=%h", bus.inst_en, bus.inst, I_NO); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic_run();
    test_breakpoint();
    test_step();
    test_halt();
    test_load_gating();
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
